tiny_dnn_pool_pe: RTL and testbench

Parametrised 2x2 pooling engine for the tiny-dnn accelerator datapath. It replaces the single-channel real-valued max-pool.
- Processes CH channels of signed fixed-point data in parallel.
- Supports max or average mode, selected per input beat.
- Produces pooled values plus, in max mode, the feature-map address of the winning element, for use by the backward pass.
- Sits between the convolution output buffer and the pooled-map writeback.

---
 rtl/tiny_dnn_pool_pe_if.sv | 30 +++
 rtl/tiny_dnn_pool_pe.sv | 262 ++++++++++++++++++++++++++
 tb/tb_tiny_dnn_pool_pe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tiny_dnn_pool_pe_if.sv
// Bundled handshake and data signals for the 2x2 pooling engine.
// The master side (the producer of windows) drives the inputs. The slave
// side is the pooling engine itself.
interface tiny_dnn_pool_pe_if #(
  parameter int DW  = 16,
  parameter int CH  = 4,
  parameter int OWW = 5,
  parameter int AW  = 16
);
  logic                 pool;
  logic                 p_fin;
  logic                 en;
  logic                 mode;
  logic [OWW-1:0]       ow;
  logic [CH*4*DW-1:0]   din;
  logic                 pool_busy;
  logic                 po_valid;
  logic [CH*DW-1:0]     po;
  logic [AW*CH-1:0]     pp;

  modport master (
    output pool, p_fin, en, mode, ow, din,
    input  pool_busy, po_valid, po, pp
  );

  modport slave (
    input  pool, p_fin, en, mode, ow, din,
    output pool_busy, po_valid, po, pp
  );
endinterface

// File: rtl/tiny_dnn_pool_pe.sv
// 2x2 max/average pooling engine, CH channels in parallel.
// It has four pipeline stages and accepts one window per cycle.
// In max mode, each result carries the input-map address of its winning element.
module tiny_dnn_pool_pe #(
  parameter int DW  = 16,
  parameter int CH  = 4,
  parameter int OWW = 5,
  parameter int AW  = 16
) (
  input logic               clk,
  input logic               reset,
  tiny_dnn_pool_pe_if.slave bus
);

  localparam int PAW = AW - 1;  // window address width; col bit appended below
  localparam int SW  = DW + 2;  // width of a four-element sum

  // ---------------------------------------------------------------------------
  // Window address counter
  // ---------------------------------------------------------------------------
  logic [OWW-1:0] px_q, px_d;
  logic [PAW-1:0] pa_q, pa_d;
  logic [PAW-1:0] ow_ext;
  logic           px_wrap;
  logic [PAW-1:0] beat_pa;
  logic           take;

  assign ow_ext  = PAW'(bus.ow);
  // ow==0 can never match, so the column counter then just free-runs
  assign px_wrap = (({1'b0, px_q} + (OWW+1)'(1)) == {1'b0, bus.ow});
  // a beat arriving together with p_fin belongs to the new map
  assign beat_pa = bus.p_fin ? '0 : pa_q;
  assign take    = bus.pool & bus.en;

  // next-state of the column / window-address counter
  always_comb begin
    px_d = px_q;
    pa_d = pa_q;
    if (!bus.pool || bus.p_fin) begin
      px_d = '0;
      pa_d = '0;
    end else if (bus.en) begin
      if (px_wrap) begin
        px_d = '0;
        pa_d = pa_q + ow_ext + PAW'(1);  // skip the odd input row
      end else begin
        px_d = px_q + OWW'(1);
        pa_d = pa_q + PAW'(1);
      end
    end
  end

  // counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_q <= '0;
      pa_q <= '0;
    end else begin
      px_q <= px_d;
      pa_q <= pa_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: capture window, mode and address
  // ---------------------------------------------------------------------------
  logic               v1_q;
  logic               m1_q;
  logic [CH*4*DW-1:0] d1_q;
  logic [PAW-1:0]     a1_q;

  // input capture stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      m1_q <= 1'b0;
      d1_q <= '0;
      a1_q <= '0;
    end else begin
      v1_q <= take;
      if (take) begin
        m1_q <= bus.mode;
        d1_q <= bus.din;
        a1_q <= beat_pa;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: column pairs (k0,k1) and (k2,k3)
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] el   [CH][4];
  logic signed [DW:0]   p0_d [CH];
  logic signed [DW:0]   p1_d [CH];
  logic                 i0_d [CH];
  logic                 i1_d [CH];
  logic signed [DW:0]   p0_q [CH];
  logic signed [DW:0]   p1_q [CH];
  logic                 i0_q [CH];
  logic                 i1_q [CH];
  logic                 v2_q;
  logic                 m2_q;
  logic [PAW-1:0]       a2_q;

  // unpack the captured window into per-channel elements
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 4; k++) begin
        el[c][k] = d1_q[(c*4+k)*DW +: DW];
      end
    end
  end

  // pair reduction: in max mode a tie keeps the lower k; in average mode each pair is summed
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      p0_d[c] = '0;
      p1_d[c] = '0;
      i0_d[c] = 1'b0;
      i1_d[c] = 1'b0;
      if (m1_q) begin
        p0_d[c] = {el[c][0][DW-1], el[c][0]} + {el[c][1][DW-1], el[c][1]};
        p1_d[c] = {el[c][2][DW-1], el[c][2]} + {el[c][3][DW-1], el[c][3]};
      end else begin
        if (el[c][1] > el[c][0]) begin
          p0_d[c] = {el[c][1][DW-1], el[c][1]};
          i0_d[c] = 1'b1;
        end else begin
          p0_d[c] = {el[c][0][DW-1], el[c][0]};
        end
        if (el[c][3] > el[c][2]) begin
          p1_d[c] = {el[c][3][DW-1], el[c][3]};
          i1_d[c] = 1'b1;
        end else begin
          p1_d[c] = {el[c][2][DW-1], el[c][2]};
        end
      end
    end
  end

  // pair stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_q <= 1'b0;
      m2_q <= 1'b0;
      a2_q <= '0;
      for (int c = 0; c < CH; c++) begin
        p0_q[c] <= '0;
        p1_q[c] <= '0;
        i0_q[c] <= 1'b0;
        i1_q[c] <= 1'b0;
      end
    end else begin
      v2_q <= v1_q & bus.pool;
      if (v1_q) begin
        m2_q <= m1_q;
        a2_q <= a1_q;
        for (int c = 0; c < CH; c++) begin
          p0_q[c] <= p0_d[c];
          p1_q[c] <= p1_d[c];
          i0_q[c] <= i0_d[c];
          i1_q[c] <= i1_d[c];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: combine the two pairs
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] r_d [CH];
  logic [1:0]           k_d [CH];
  logic signed [SW-1:0] r_q [CH];
  logic [1:0]           k_q [CH];
  logic                 v3_q;
  logic                 m3_q;
  logic [PAW-1:0]       a3_q;

  // final reduction: in max mode a tie keeps the (k0,k1) winner; in average mode the pair sums are added
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      r_d[c] = '0;
      k_d[c] = 2'd0;
      if (m2_q) begin
        r_d[c] = {p0_q[c][DW], p0_q[c]} + {p1_q[c][DW], p1_q[c]};
      end else if (p1_q[c] > p0_q[c]) begin
        r_d[c] = {p1_q[c][DW], p1_q[c]};
        k_d[c] = {1'b1, i1_q[c]};
      end else begin
        r_d[c] = {p0_q[c][DW], p0_q[c]};
        k_d[c] = {1'b0, i0_q[c]};
      end
    end
  end

  // combine stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3_q <= 1'b0;
      m3_q <= 1'b0;
      a3_q <= '0;
      for (int c = 0; c < CH; c++) begin
        r_q[c] <= '0;
        k_q[c] <= 2'd0;
      end
    end else begin
      v3_q <= v2_q & bus.pool;
      if (v2_q) begin
        m3_q <= m2_q;
        a3_q <= a2_q;
        for (int c = 0; c < CH; c++) begin
          r_q[c] <= r_d[c];
          k_q[c] <= k_d[c];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S4: output register
  // ---------------------------------------------------------------------------
  logic [CH*DW-1:0] po_d, po_q;
  logic [AW*CH-1:0] pp_d, pp_q;
  logic             po_valid_q;

  // result formatting: averages take the top DW bits of the sum (floor of sum/4),
  // and max results carry the winner's address
  always_comb begin
    po_d = '0;
    pp_d = '0;
    for (int c = 0; c < CH; c++) begin
      if (m3_q) begin
        po_d[c*DW +: DW] = r_q[c][SW-1:2];
        pp_d[c*AW +: AW] = {a3_q, 1'b0};
      end else begin
        po_d[c*DW +: DW] = r_q[c][DW-1:0];
        pp_d[c*AW +: AW] = {PAW'(a3_q + (k_q[c][0] ? ow_ext : PAW'(0))), k_q[c][1]};
      end
    end
  end

  // output registers hold their value between strobes and when a beat is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      po_valid_q <= 1'b0;
      po_q       <= '0;
      pp_q       <= '0;
    end else begin
      po_valid_q <= v3_q & bus.pool;
      if (v3_q && bus.pool) begin
        po_q <= po_d;
        pp_q <= pp_d;
      end
    end
  end

  assign bus.po_valid  = po_valid_q;
  assign bus.po        = po_q;
  assign bus.pp        = pp_q;
  assign bus.pool_busy = v1_q | v2_q | v3_q | po_valid_q;

endmodule

// File: tb/tb_tiny_dnn_pool_pe.sv
// Directed bench for the 2x2 pooling engine. Expected results are hand-computed
// constants queued together with their due cycle.
module tb_tiny_dnn_pool_pe;
  localparam int DW  = 16;
  localparam int CH  = 4;
  localparam int OWW = 5;
  localparam int AW  = 16;

  typedef struct {
    logic [63:0] po;
    logic [63:0] pp;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t expq[$];
  logic signed [DW-1:0] w [CH][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tiny_dnn_pool_pe_if #(.DW(DW), .CH(CH), .OWW(OWW), .AW(AW)) bus ();

  tiny_dnn_pool_pe #(.DW(DW), .CH(CH), .OWW(OWW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic clrw();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < 4; k++)
        w[c][k] = '0;
  endtask

  task automatic setw(input int c, input int k0, input int k1, input int k2, input int k3);
    w[c][0] = 16'(k0);
    w[c][1] = 16'(k1);
    w[c][2] = 16'(k2);
    w[c][3] = 16'(k3);
  endtask

  task automatic beat(input logic m, input logic fin);
    @(negedge clk);
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < 4; k++)
        bus.din[(c*4+k)*DW +: DW] = w[c][k];
    bus.mode  = m;
    bus.en    = 1'b1;
    bus.p_fin = fin;
  endtask

  task automatic push(input logic [63:0] po, input logic [63:0] pp);
    exp_t e;
    e.po  = po;
    e.pp  = pp;
    e.due = cyc + 4;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.en    = 1'b0;
      bus.p_fin = 1'b0;
    end
  endtask

  // output monitor: every strobe must match the head of the expectation queue
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (bus.po_valid === 1'b1) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", {63'b0, bus.po_valid}, 64'd0);
        end else begin
          e = expq.pop_front();
          chk("po", bus.po, e.po);
          chk("pp", bus.pp, e.pp);
          chk("latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.pool  = 1'b0;
    bus.p_fin = 1'b0;
    bus.en    = 1'b0;
    bus.mode  = 1'b0;
    bus.ow    = 5'd4;
    bus.din   = '0;
    clrw();
    repeat (2) @(negedge clk);
    chk("rst_po", bus.po, 64'd0);
    chk("rst_pp", bus.pp, 64'd0);
    chk("rst_valid", {63'b0, bus.po_valid}, 64'd0);
    chk("rst_busy", {63'b0, bus.pool_busy}, 64'd0);
    reset    = 1'b0;
    bus.pool = 1'b1;
    idle(1);

    // max basic, ties and most-negative values (ow=4, pa=0)
    setw(0, 5, 9, 3, 1);
    setw(1, -32768, -32768, -32768, -32768);
    setw(2, 1, 2, 7, 7);
    setw(3, 0, 0, 0, 0);
    beat(1'b0, 1'b0);
    push(pk4(9, -32768, 7, 0), pk4(8, 0, 1, 0));
    // average floor and no overflow (pa=1)
    setw(0, 1, 2, 2, 2);
    setw(1, -1, -1, -1, -2);
    setw(2, 32767, 32767, 32767, 32767);
    setw(3, -32768, -32768, -32768, -32768);
    beat(1'b1, 1'b0);
    push(pk4(1, -2, 32767, -32768), pk4(2, 2, 2, 2));
    idle(6);
    chk("idle_busy", {63'b0, bus.pool_busy}, 64'd0);

    // row wrap with ow=2: pa 0,1,4,5,8
    @(negedge clk);
    bus.p_fin = 1'b1;
    bus.ow    = 5'd2;
    clrw();
    setw(0, 100, 0, 0, 0);
    beat(1'b0, 1'b0); push(pk4(100, 0, 0, 0), pk4(0, 0, 0, 0));
    beat(1'b0, 1'b0); push(pk4(100, 0, 0, 0), pk4(2, 2, 2, 2));
    beat(1'b0, 1'b0); push(pk4(100, 0, 0, 0), pk4(8, 8, 8, 8));
    beat(1'b0, 1'b0); push(pk4(100, 0, 0, 0), pk4(10, 10, 10, 10));
    beat(1'b0, 1'b0); push(pk4(100, 0, 0, 0), pk4(16, 16, 16, 16));
    idle(4);
    chk("busy_last_out", {63'b0, bus.pool_busy}, 64'd1);
    idle(1);
    chk("busy_fall", {63'b0, bus.pool_busy}, 64'd0);

    // mode interleave with ow=8: pa 0..3
    @(negedge clk);
    bus.p_fin = 1'b1;
    bus.ow    = 5'd8;
    clrw();
    setw(0, 4, -8, 10, 2);
    setw(3, -3, -3, -3, -3);
    beat(1'b0, 1'b0); push(pk4(10, 0, 0, -3), pk4(1, 0, 0, 0));
    beat(1'b1, 1'b0); push(pk4(2, 0, 0, -3), pk4(2, 2, 2, 2));
    beat(1'b0, 1'b0); push(pk4(10, 0, 0, -3), pk4(5, 4, 4, 4));
    beat(1'b1, 1'b0); push(pk4(2, 0, 0, -3), pk4(6, 6, 6, 6));
    idle(6);

    // abort: three beats are dropped and the outputs hold
    clrw();
    setw(0, 50, 0, 0, 0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    @(negedge clk);
    bus.en   = 1'b0;
    bus.pool = 1'b0;
    idle(1);
    chk("abort_busy", {63'b0, bus.pool_busy}, 64'd0);
    chk("abort_hold_po", bus.po, pk4(2, 0, 0, -3));
    chk("abort_hold_pp", bus.pp, pk4(6, 6, 6, 6));
    bus.pool = 1'b1;
    idle(4);
    clrw();
    setw(0, 0, 0, 0, 5);
    beat(1'b0, 1'b0); push(pk4(5, 0, 0, 0), pk4(17, 0, 0, 0));
    idle(6);

    // p_fin together with en: this beat uses pa=0 (the counter was at pa=1)
    clrw();
    setw(0, 1, 2, 3, 9);
    beat(1'b0, 1'b1); push(pk4(9, 0, 0, 0), pk4(17, 0, 0, 0));
    idle(6);

    // async reset mid-clock with beats in flight
    setw(0, 7, 0, 0, 0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    idle(2);
    chk("pre_rst_busy", {63'b0, bus.pool_busy}, 64'd1);
    #2;
    reset = 1'b1;
    expq.delete();
    #1;
    chk("arst_po", bus.po, 64'd0);
    chk("arst_pp", bus.pp, 64'd0);
    chk("arst_valid", {63'b0, bus.po_valid}, 64'd0);
    chk("arst_busy", {63'b0, bus.pool_busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    chk("drain", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
